// File: rtl/uart_top.sv
// uart_top: full-duplex UART with a byte-wide host port and a fixed 100 MHz baud table.
module uart_top (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_baud,
  input  logic       i_write,
  input  logic [1:0] i_read,
  input  logic [7:0] i_byte,
  input  logic       i_rx,
  input  logic       i_eight,
  input  logic       i_pen,
  input  logic       i_ohel,
  output logic       o_TX,
  output logic       o_UART_INTR,
  output logic [7:0] o_UART_DS
);

  localparam int unsigned CNT_W = 19;
  localparam int unsigned TX_W  = 11;
  localparam int unsigned RXB_W = 9;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;

  logic [CNT_W-1:0] k_c;
  logic [CNT_W-1:0] half_c;
  logic [TX_W-1:0]  tx_frame_c;
  logic [1:0]       tx_hi_c;
  logic             p7_c;
  logic             p8_c;

  logic [TX_W-1:0]  tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             txrdy_q, txrdy_d;

  logic             rx_meta_q, rx_sync_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [RXB_W-1:0] rx_buf_q, rx_buf_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rxrdy_q, rxrdy_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       rx_n_c;
  logic [7:0]       rx_word_c;
  logic             rx_par_c;

  logic             txrdy_dly_q, rxrdy_dly_q;
  logic             intr_q, intr_d;

  // Clocks per bit for the selected rate; half-bit used to find the start-bit centre.
  always_comb begin
    case (i_baud)
      4'd0:    k_c = CNT_W'(333333);
      4'd1:    k_c = CNT_W'(83333);
      4'd2:    k_c = CNT_W'(41667);
      4'd3:    k_c = CNT_W'(20833);
      4'd4:    k_c = CNT_W'(10417);
      4'd5:    k_c = CNT_W'(5208);
      4'd6:    k_c = CNT_W'(2604);
      4'd7:    k_c = CNT_W'(1736);
      4'd8:    k_c = CNT_W'(868);
      4'd9:    k_c = CNT_W'(434);
      4'd10:   k_c = CNT_W'(217);
      default: k_c = CNT_W'(109);
    endcase
    half_c = k_c >> 1;
  end

  // Build the 11-bit transmit frame: start, D0..D6, two config-dependent bits, stop.
  always_comb begin
    p7_c = (^i_byte[6:0]) ^ i_ohel;
    p8_c = (^i_byte) ^ i_ohel;
    case ({i_eight, i_pen})
      2'b00:   tx_hi_c = 2'b11;
      2'b01:   tx_hi_c = {1'b1, p7_c};
      2'b10:   tx_hi_c = {1'b1, i_byte[7]};
      default: tx_hi_c = {p8_c, i_byte[7]};
    endcase
    tx_frame_c = {1'b1, tx_hi_c, i_byte[6:0], 1'b0};
  end

  // Transmit engine: load on write when ready, shift one bit every K clocks.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    txrdy_d    = txrdy_q;
    if (txrdy_q) begin
      if (i_write) begin
        tx_shift_d = tx_frame_c;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txrdy_d    = 1'b0;
      end
    end else if (tx_cnt_q == k_c - CNT_W'(1)) begin
      tx_cnt_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[TX_W-1:1]};
      if (tx_bit_q == 4'd10) txrdy_d = 1'b1;
      else                   tx_bit_d = tx_bit_q + 4'd1;
    end else begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end
  end

  // Received word and parity bit as laid out in the sample buffer.
  always_comb begin
    rx_n_c    = (i_eight ? 4'd8 : 4'd7) + {3'b000, i_pen} + 4'd1;
    rx_word_c = i_eight ? rx_buf_q[7:0] : {1'b0, rx_buf_q[6:0]};
    rx_par_c  = i_eight ? rx_buf_q[8] : rx_buf_q[7];
  end

  // Receive FSM and host-visible flags; a completing frame overrides a read clear.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_buf_d   = rx_buf_q;
    rx_data_d  = rx_data_q;
    rxrdy_d    = rxrdy_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;
    if (i_read[0]) begin
      rxrdy_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == half_c - CNT_W'(1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == k_c - CNT_W'(1)) begin
          rx_cnt_d = '0;
          if (rx_bit_q == rx_n_c - 4'd1) begin
            rx_state_d = RX_IDLE;
            rx_data_d  = rx_word_c;
            perr_d     = i_pen && (rx_par_c != ((^rx_word_c) ^ i_ohel));
            ferr_d     = ~rx_sync_q;
            ovf_d      = rxrdy_q;
            rxrdy_d    = 1'b1;
          end else begin
            rx_buf_d[rx_bit_q] = rx_sync_q;
            rx_bit_d           = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Interrupt on a rising edge of either ready flag.
  always_comb begin
    intr_d = (txrdy_q & ~txrdy_dly_q) | (rxrdy_q & ~rxrdy_dly_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      txrdy_q     <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_buf_q    <= '0;
      rx_data_q   <= '0;
      rxrdy_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      txrdy_dly_q <= 1'b1;
      rxrdy_dly_q <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      txrdy_q     <= txrdy_d;
      rx_meta_q   <= i_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_buf_q    <= rx_buf_d;
      rx_data_q   <= rx_data_d;
      rxrdy_q     <= rxrdy_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      txrdy_dly_q <= txrdy_q;
      rxrdy_dly_q <= rxrdy_q;
      intr_q      <= intr_d;
    end
  end

  assign o_TX        = tx_shift_q[0];
  assign o_UART_INTR = intr_q;
  assign o_UART_DS   = i_read[1] ? {3'b000, ovf_q, ferr_q, perr_q, txrdy_q, rxrdy_q}
                                 : rx_data_q;

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: scoreboard-driven bench for uart_top at 921600 baud (K = 109).
`timescale 1ns/1ps
module tb_uart_top;

  localparam int K = 109;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] baud;
  logic       wr;
  logic [1:0] rd;
  logic [7:0] tx_byte;
  logic       rx_drv;
  logic       loop_en;
  logic       rx_line;
  logic       eight, pen, ohel;
  logic       tx;
  logic       intr;
  logic [7:0] ds;

  int n_checks = 0;
  int n_fail   = 0;
  int intr_hi  = 0;

  logic       tx_exp_q[$];
  logic [7:0] rx_exp_data_q[$];
  logic [7:0] rx_exp_stat_q[$];

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_top dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_baud      (baud),
    .i_write     (wr),
    .i_read      (rd),
    .i_byte      (tx_byte),
    .i_rx        (rx_line),
    .i_eight     (eight),
    .i_pen       (pen),
    .i_ohel      (ohel),
    .o_TX        (tx),
    .o_UART_INTR (intr),
    .o_UART_DS   (ds)
  );

  // Count interrupt-high cycles, sampled away from the active edge.
  always @(negedge clk) if (intr === 1'b1) intr_hi++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_status(output logic [7:0] s);
    rd = 2'b10;
    #1;
    s  = ds;
    rd = 2'b00;
  endtask

  task automatic read_data(output logic [7:0] d);
    rd = 2'b00;
    #1;
    d = ds;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr      = 1'b1;
    tx_byte = b;
    tick();
    wr      = 1'b0;
  endtask

  task automatic clear_flags();
    rd = 2'b01;
    tick();
    rd = 2'b00;
  endtask

  // Reference frame: start, data LSB first, optional parity, ones to fill 11 bits.
  function automatic logic [10:0] model_frame(input logic [7:0] b, input logic e,
                                              input logic p, input logic o);
    logic [10:0] f;
    logic        par;
    int          nd;
    f    = '1;
    f[0] = 1'b0;
    par  = o;
    nd   = e ? 8 : 7;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = b[i];
      par    = par ^ b[i];
    end
    if (p) f[1+nd] = par;
    return f;
  endfunction

  task automatic push_tx(input logic [10:0] f);
    for (int i = 0; i < 11; i++) tx_exp_q.push_back(f[i]);
  endtask

  // Consume 11 expected bits; caller sits just after the load edge.
  task automatic watch_tx_frame(input string name, input bit inject);
    logic       e;
    logic [7:0] s;
    for (int i = 0; i < 11; i++) begin
      e = tx_exp_q.pop_front();
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL %s bit%0d start: o_TX=%b required %b", name, i, tx, e);
      end
      for (int j = 1; j < K; j++) begin
        if (inject && i == 3 && j == 10) begin
          wr      = 1'b1;
          tx_byte = 8'hFF;
        end
        tick();
        wr = 1'b0;
      end
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL %s bit%0d end: o_TX=%b required %b", name, i, tx, e);
      end
      if (i == 10) begin
        read_status(s);
        n_checks++;
        if (s[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s txrdy_early: TXRDY=%b required 0", name, s[1]);
        end
      end
      tick();
    end
    read_status(s);
    n_checks++;
    if (s[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s txrdy_at_11K: TXRDY=%b required 1", name, s[1]);
    end
  endtask

  // Wait (bounded) for RXRDY, then pop and compare status and data.
  task automatic check_rx(input string name);
    logic [7:0] s, d, ed, es;
    int         waited;
    waited = 0;
    read_status(s);
    while (s[0] !== 1'b1 && waited < 4 * 11 * K) begin
      tick();
      read_status(s);
      waited++;
    end
    n_checks++;
    if (s[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rx_timeout: status=%h required RXRDY=1", name, s);
    end
    ed = rx_exp_data_q.pop_front();
    es = rx_exp_stat_q.pop_front();
    read_status(s);
    n_checks++;
    if (s !== es) begin
      n_fail++;
      $display("FAIL %s rx_status: got %h required %h", name, s, es);
    end
    read_data(d);
    n_checks++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL %s rx_data: got %h required %h", name, d, ed);
    end
  endtask

  // Drive a frame on the receive line; the last bit may be held shorter.
  task automatic send_frame(input logic [10:0] f, input int last_len);
    for (int i = 0; i < 11; i++) begin
      rx_drv = f[i];
      ticks(i == 10 ? last_len : K);
    end
    rx_drv = 1'b1;
    ticks(K);
  endtask

  task automatic test_reset();
    logic [7:0] s, d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b required 0", intr); end
    read_data(d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", d); end
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h required 02", s); end
  endtask

  task automatic test_tx_even();
    logic [7:0] s;
    int         i0;
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; loop_en = 1'b0;
    i0 = intr_hi;
    push_tx(11'b10011010100);
    write_byte(8'h6A);
    read_status(s);
    n_checks++;
    if (s !== 8'h00) begin n_fail++; $display("FAIL tx_even_load_status: got %h required 00", s); end
    watch_tx_frame("tx_even", 1'b0);
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL tx_even_intr_pre: got %b required 0", intr); end
    tick();
    n_checks++;
    if (intr !== 1'b1) begin n_fail++; $display("FAIL tx_even_intr_pulse: got %b required 1", intr); end
    tick();
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL tx_even_intr_post: got %b required 0", intr); end
    ticks(2);
    n_checks++;
    if (intr_hi - i0 !== 1) begin
      n_fail++;
      $display("FAIL tx_even_intr_count: got %0d required 1", intr_hi - i0);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] s;
    int         i0;
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; loop_en = 1'b1;
    i0 = intr_hi;
    push_tx(model_frame(8'h6A, 1'b1, 1'b1, 1'b0));
    rx_exp_data_q.push_back(8'h6A);
    rx_exp_stat_q.push_back(8'h03);
    write_byte(8'h6A);
    watch_tx_frame("loopback", 1'b0);
    check_rx("loopback");
    ticks(3);
    n_checks++;
    if (intr_hi - i0 !== 2) begin
      n_fail++;
      $display("FAIL loopback_intr_count: got %0d required 2", intr_hi - i0);
    end
    clear_flags();
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL loopback_clear: got %h required 02", s); end
    loop_en = 1'b0;
  endtask

  task automatic test_odd7();
    eight = 1'b0; pen = 1'b1; ohel = 1'b1; loop_en = 1'b1;
    push_tx(11'b11111010100);
    rx_exp_data_q.push_back(8'h6A);
    rx_exp_stat_q.push_back(8'h03);
    write_byte(8'h6A);
    watch_tx_frame("odd7", 1'b0);
    check_rx("odd7");
    clear_flags();
    loop_en = 1'b0;
    ticks(4);
  endtask

  task automatic test_errors();
    logic [10:0] f;
    logic [7:0]  s;
    int          i0;
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; loop_en = 1'b0;
    f    = model_frame(8'h55, 1'b1, 1'b1, 1'b0);
    f[9] = ~f[9];
    rx_exp_data_q.push_back(8'h55);
    rx_exp_stat_q.push_back(8'h07);
    send_frame(f, K);
    check_rx("perr");
    clear_flags();

    f     = model_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    f[10] = 1'b0;
    rx_exp_data_q.push_back(8'hA3);
    rx_exp_stat_q.push_back(8'h0B);
    send_frame(f, 70);
    check_rx("ferr");
    clear_flags();
    ticks(2 * K);
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL ferr_clear: got %h required 02", s); end

    i0 = intr_hi;
    rx_exp_data_q.push_back(8'h22);
    rx_exp_stat_q.push_back(8'h13);
    send_frame(model_frame(8'h11, 1'b1, 1'b1, 1'b0), K);
    send_frame(model_frame(8'h22, 1'b1, 1'b1, 1'b0), K);
    check_rx("ovf");
    n_checks++;
    if (intr_hi - i0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_intr_count: got %0d required 1", intr_hi - i0);
    end
    clear_flags();
  endtask

  task automatic test_busy_write();
    logic [7:0] s;
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; loop_en = 1'b0;
    push_tx(model_frame(8'h6A, 1'b1, 1'b1, 1'b0));
    write_byte(8'h6A);
    watch_tx_frame("busy_write", 1'b1);
    ticks(K);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL busy_write_idle: o_TX=%b required 1", tx); end
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL busy_write_status: got %h required 02", s); end
  endtask

  task automatic test_false_start();
    logic [7:0] s, d;
    rx_drv = 1'b0;
    ticks(20);
    rx_drv = 1'b1;
    ticks(2 * K);
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL false_start_status: got %h required 02", s); end
    read_data(d);
    n_checks++;
    if (d !== 8'h22) begin n_fail++; $display("FAIL false_start_data: got %h required 22", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s, d;
    int         i0;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; loop_en = 1'b1;
    write_byte(8'hC3);
    ticks(5 * K);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i0 = intr_hi;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b required 1", tx); end
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL midreset_status: got %h required 02", s); end
    read_data(d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h required 00", d); end
    ticks(12 * K);
    read_status(s);
    n_checks++;
    if (s !== 8'h02) begin n_fail++; $display("FAIL midreset_rx_abort: got %h required 02", s); end
    n_checks++;
    if (intr_hi - i0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_intr: got %0d pulses required 0", intr_hi - i0);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; baud = 4'd11; wr = 1'b0; rd = 2'b00; tx_byte = 8'h00;
    rx_drv = 1'b1; loop_en = 1'b0; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    test_reset();
    test_tx_even();
    test_loopback();
    test_odd7();
    test_errors();
    test_busy_write();
    test_false_start();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
